fu_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 4-in/2-out function unit (x[1:4] -> F[1:2]) among N_REQ requesters. It grants one requester at a time, drives that requester's operand onto the unit, and waits one settle cycle. It then captures the unit's output into a registered response that is steered back to the granted requester. It sits between the exercise function unit and the stimulus/consumer blocks that share it.

---
 rtl/fu_rr_arbiter.sv | 96 +++++++++
 tb/tb_fu_rr_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fu_rr_arbiter.sv
// fu_rr_arbiter: round-robin arbiter/sequencer sharing one combinational function unit among N_REQ requesters
module fu_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int XW    = 4,
    parameter int FW    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*XW-1:0] req_x,
    output logic [N_REQ-1:0]    gnt,
    output logic [XW-1:0]       fu_x,
    input  logic [FW-1:0]       fu_F,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [FW-1:0]       rsp_F,
    output logic                busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;

    state_t             r_state, w_state_nxt;
    logic [IW-1:0]      r_last, w_last_nxt;
    logic [IW-1:0]      r_win, w_win_nxt;
    logic [IW-1:0]      w_pick, w_idx;
    logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0]   r_rsp_valid, w_rsp_valid_nxt;
    logic [XW-1:0]      r_fu_x, w_fu_x_nxt;
    logic [FW-1:0]      r_rsp_F, w_rsp_F_nxt;

    // Nearest active requester after r_last wins; scanning far-to-near lets the nearest overwrite
    always_comb begin
        w_pick = r_last;
        w_idx  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = IW'((int'(r_last) + k) % N_REQ);
            if (req[w_idx]) w_pick = w_idx;
        end
    end

    // Next state and next registered outputs; pointer moves only when the response is captured
    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_win_nxt       = r_win;
        w_gnt_nxt       = '0;
        w_rsp_valid_nxt = '0;
        w_fu_x_nxt      = r_fu_x;
        w_rsp_F_nxt     = r_rsp_F;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_win_nxt   = w_pick;
                    w_gnt_nxt   = N_REQ'(1) << w_pick;
                    w_fu_x_nxt  = req_x[int'(w_pick)*XW +: XW];
                    w_state_nxt = DRIVE;
                end
            end
            DRIVE: w_state_nxt = CAPTURE;
            CAPTURE: begin
                w_rsp_F_nxt     = fu_F;
                w_rsp_valid_nxt = N_REQ'(1) << r_win;
                w_last_nxt      = r_win;
                w_state_nxt     = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= IW'(N_REQ - 1);
            r_win       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_fu_x      <= '0;
            r_rsp_F     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_win       <= w_win_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_fu_x      <= w_fu_x_nxt;
            r_rsp_F     <= w_rsp_F_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign fu_x      = r_fu_x;
    assign rsp_valid = r_rsp_valid;
    assign rsp_F     = r_rsp_F;
    assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_fu_rr_arbiter.sv
// tb_fu_rr_arbiter: table-driven and directed checks of the round-robin function-unit arbiter
module tb_fu_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_x;
    logic [3:0]  gnt;
    logic [3:0]  fu_x;
    logic [1:0]  fu_F;
    logic [3:0]  rsp_valid;
    logic [1:0]  rsp_F;
    logic        busy;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] rx;
        logic [3:0]  gnt;
        logic [3:0]  fx;
        logic [3:0]  rv;
        logic [1:0]  rf;
        logic        busy;
    } vec_t;

    vec_t tbl[32];

    // Reference function unit, x[1] is the MSB of the operand
    function automatic logic [1:0] fu_model(input logic [3:0] x);
        logic x1, x2, x3, x4;
        {x1, x2, x3, x4} = x;
        return {x1 | (x2 & ~x4) | (x3 & ~x4), (x1 | x2 | x4) & (x1 | ~x3 | ~x4)};
    endfunction

    assign fu_F = fu_model(fu_x);

    fu_rr_arbiter #(.N_REQ(4), .XW(4), .FW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .gnt(gnt), .fu_x(fu_x),
        .fu_F(fu_F), .rsp_valid(rsp_valid), .rsp_F(rsp_F), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        // req, req_x, gnt, fu_x, rsp_valid, rsp_F, busy (after the edge)
        tbl = '{
            '{4'b1111, 16'h8310, 4'b0001, 4'h0, 4'b0000, 2'b00, 1'b1},
            '{4'b1111, 16'h8310, 4'b0000, 4'h0, 4'b0000, 2'b00, 1'b1},
            '{4'b1111, 16'h8310, 4'b0000, 4'h0, 4'b0001, 2'b00, 1'b0},
            '{4'b1111, 16'h8310, 4'b0010, 4'h1, 4'b0000, 2'b00, 1'b1},
            '{4'b1111, 16'h8310, 4'b0000, 4'h1, 4'b0000, 2'b00, 1'b1},
            '{4'b1111, 16'h8310, 4'b0000, 4'h1, 4'b0010, 2'b01, 1'b0},
            '{4'b1111, 16'h8310, 4'b0100, 4'h3, 4'b0000, 2'b01, 1'b1},
            '{4'b1111, 16'h8310, 4'b0000, 4'h3, 4'b0000, 2'b01, 1'b1},
            '{4'b1111, 16'h8310, 4'b0000, 4'h3, 4'b0100, 2'b00, 1'b0},
            '{4'b1111, 16'h8310, 4'b1000, 4'h8, 4'b0000, 2'b00, 1'b1},
            '{4'b1111, 16'h8310, 4'b0000, 4'h8, 4'b0000, 2'b00, 1'b1},
            '{4'b1111, 16'h8310, 4'b0000, 4'h8, 4'b1000, 2'b11, 1'b0},
            '{4'b1111, 16'h8310, 4'b0001, 4'h0, 4'b0000, 2'b11, 1'b1},
            '{4'b1111, 16'h8310, 4'b0000, 4'h0, 4'b0000, 2'b11, 1'b1},
            '{4'b1111, 16'h8310, 4'b0000, 4'h0, 4'b0001, 2'b00, 1'b0},
            '{4'b1000, 16'h8310, 4'b1000, 4'h8, 4'b0000, 2'b00, 1'b1},
            '{4'b1000, 16'h8310, 4'b0000, 4'h8, 4'b0000, 2'b00, 1'b1},
            '{4'b1000, 16'h8310, 4'b0000, 4'h8, 4'b1000, 2'b11, 1'b0},
            '{4'b1001, 16'h8310, 4'b0001, 4'h0, 4'b0000, 2'b11, 1'b1},
            '{4'b1001, 16'h8310, 4'b0000, 4'h0, 4'b0000, 2'b11, 1'b1},
            '{4'b1001, 16'h8310, 4'b0000, 4'h0, 4'b0001, 2'b00, 1'b0},
            '{4'b1001, 16'h8310, 4'b1000, 4'h8, 4'b0000, 2'b00, 1'b1},
            '{4'b1001, 16'h8310, 4'b0000, 4'h8, 4'b0000, 2'b00, 1'b1},
            '{4'b1001, 16'h8310, 4'b0000, 4'h8, 4'b1000, 2'b11, 1'b0},
            '{4'b0000, 16'h8310, 4'b0000, 4'h8, 4'b0000, 2'b11, 1'b0},
            '{4'b0001, 16'h8316, 4'b0001, 4'h6, 4'b0000, 2'b11, 1'b1},
            '{4'b0100, 16'h8316, 4'b0000, 4'h6, 4'b0000, 2'b11, 1'b1},
            '{4'b0000, 16'h8316, 4'b0000, 4'h6, 4'b0001, 2'b11, 1'b0},
            '{4'b0000, 16'h8316, 4'b0000, 4'h6, 4'b0000, 2'b11, 1'b0},
            '{4'b0001, 16'h8316, 4'b0001, 4'h6, 4'b0000, 2'b11, 1'b1},
            '{4'b0000, 16'h8316, 4'b0000, 4'h6, 4'b0000, 2'b11, 1'b1},
            '{4'b0000, 16'h8316, 4'b0000, 4'h6, 4'b0001, 2'b11, 1'b0}
        };

        rst_n = 1'b0;
        req   = '0;
        req_x = '0;
        repeat (2) step();
        chk("reset_outputs", {17'd0, gnt, fu_x, rsp_valid, rsp_F, busy}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            req   = tbl[i].req;
            req_x = tbl[i].rx;
            step();
            chk($sformatf("vec%0d", i), {17'd0, gnt, fu_x, rsp_valid, rsp_F, busy},
                {17'd0, tbl[i].gnt, tbl[i].fx, tbl[i].rv, tbl[i].rf, tbl[i].busy});
        end

        // Reset while in DRIVE: outputs clear at once and the transaction never responds
        req   = 4'b0010;
        req_x = 16'h0050;
        step();
        chk("mid_gnt", {28'd0, gnt}, 32'h2);
        req = '0;
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {17'd0, gnt, fu_x, rsp_valid, rsp_F, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_reset_idle", {27'd0, rsp_valid, busy}, 32'd0);
        end

        // Requester 1 sweeps every operand back-to-back
        req = 4'b0010;
        for (int x = 0; x < 16; x++) begin
            int w;
            req_x = {8'h00, 4'(x), 4'h0};
            step();
            w = 1;
            while (gnt == 4'b0000 && w < 6) begin
                step();
                w++;
            end
            chk($sformatf("sweep%0d_gnt", x), {28'd0, gnt}, 32'h2);
            chk($sformatf("sweep%0d_fu_x", x), {28'd0, fu_x}, 32'(x));
            req_x = '0;
            step();
            chk($sformatf("sweep%0d_drive", x), {27'd0, rsp_valid, busy}, 32'h1);
            step();
            chk($sformatf("sweep%0d_rsp", x), {25'd0, rsp_valid, rsp_F, busy},
                {25'd0, 4'b0010, fu_model(4'(x)), 1'b0});
        end
        req = '0;
        step();
        chk("final_idle", {23'd0, gnt, rsp_valid, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
